// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared playfield types, screen constants and lane wrap arithmetic
package frogger_pkg;

    typedef logic signed [10:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Objects re-enter from the opposite edge; the wrap period is screen + object width.
    function automatic coord_t wrap_step(coord_t x, dir_e d, int step, int w, int screen);
        int n;
        if (d == DIR_RIGHT) begin
            n = int'(x) + step;
            if (n >= screen) n = n - (screen + w);
        end else begin
            n = int'(x) - step;
            if (n <= -w) n = n + (screen + w);
        end
        return coord_t'(n);
    endfunction

endpackage

// File: rtl/lane_object.sv
// rtl/lane_object.sv - one lane object position register with wrap-around stepping
module lane_object #(
    parameter int OBJ_W    = 40,
    parameter int SCREEN_W = 640,
    parameter int STEP     = 10
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic signed [10:0] reset_x_i,
    input  logic               move_i,
    input  logic               dir_i,
    output logic signed [10:0] x_o
);
    import frogger_pkg::*;

    coord_t x_q;
    coord_t x_d;

    always_comb begin
        x_d = x_q;
        if (move_i) x_d = wrap_step(x_q, dir_e'(dir_i), STEP, OBJ_W, SCREEN_W);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) x_q <= reset_x_i;
        else       x_q <= x_d;
    end

    assign x_o = x_q;

endmodule

// File: rtl/lane_mover.sv
// rtl/lane_mover.sv - N-object Frogger lane: frame schedule, object movers, probe hit and ride delta
module lane_mover #(
    parameter int NUM_OBJ     = 4,
    parameter int OBJ_W       = 40,
    parameter int OBJ_H       = 40,
    parameter int SCREEN_W    = 640,
    parameter int STEP        = 10,
    parameter int WAIT_FRAMES = 2,
    parameter int SPACING     = 170
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     enable,
    input  logic                     direction,
    input  logic signed [10:0]       start_x,
    input  logic        [10:0]       lane_y,
    input  logic signed [10:0]       probe_x,
    output logic [11*NUM_OBJ-1:0]    obj_x,
    output logic        [10:0]       obj_y,
    output logic        [10:0]       obj_width,
    output logic        [10:0]       obj_height,
    output logic                     probe_hit,
    output logic        [2:0]        hit_index,
    output logic                     moved,
    output logic signed [10:0]       delta_x
);
    import frogger_pkg::*;

    localparam int         PERIOD    = SCREEN_W + OBJ_W;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_FRAMES);
    localparam coord_t     STEP_C    = coord_t'(STEP);

    logic [7:0]  cnt_q, cnt_d;
    logic        moved_q;
    coord_t      delta_q, delta_d;
    logic [10:0] y_q;
    logic        move_evt;
    coord_t      xs [NUM_OBJ];

    // Initial layout: evenly spaced from start_x, folded once into the visible+margin band.
    function automatic coord_t reset_pos(coord_t sx, int idx);
        int n;
        n = int'(sx) + idx * SPACING;
        if (n >= SCREEN_W) n = n - PERIOD;
        return coord_t'(n);
    endfunction

    assign move_evt = enable && (cnt_q == WAIT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enable) cnt_d = move_evt ? 8'd0 : cnt_q + 8'd1;
        delta_d = '0;
        if (move_evt) delta_d = direction ? STEP_C : -STEP_C;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= '0;
            moved_q <= 1'b0;
            delta_q <= '0;
            y_q     <= lane_y;
        end else begin
            cnt_q   <= cnt_d;
            moved_q <= move_evt;
            delta_q <= delta_d;
        end
    end

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        lane_object #(
            .OBJ_W    (OBJ_W),
            .SCREEN_W (SCREEN_W),
            .STEP     (STEP)
        ) u_obj (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .reset_x_i (reset_pos(start_x, i)),
            .move_i    (move_evt),
            .dir_i     (direction),
            .x_o       (xs[i])
        );
        assign obj_x[11*i +: 11] = xs[i];
    end

    // Scan from the top index down so the lowest overlapping object wins.
    always_comb begin
        probe_hit = 1'b0;
        hit_index = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if ((int'(xs[i]) <= int'(probe_x)) && (int'(probe_x) < int'(xs[i]) + OBJ_W)) begin
                probe_hit = 1'b1;
                hit_index = 3'(i);
            end
        end
    end

    assign obj_y      = y_q;
    assign obj_width  = 11'(OBJ_W);
    assign obj_height = 11'(OBJ_H);
    assign moved      = moved_q;
    assign delta_x    = delta_q;

endmodule

// File: tb/tb_lane_mover.sv
// tb/tb_lane_mover.sv - scoreboard bench for lane_mover with directed hand-computed vectors
module tb_lane_mover;

    logic               frame_clk = 1'b0;
    logic               Reset     = 1'b0;
    logic               enable    = 1'b1;
    logic               direction = 1'b0;
    logic signed [10:0] start_x   = '0;
    logic        [10:0] lane_y    = 11'd200;
    logic signed [10:0] probe_x   = -11'sd500;
    logic        [43:0] obj_x;
    logic        [10:0] obj_y;
    logic        [10:0] obj_width;
    logic        [10:0] obj_height;
    logic               probe_hit;
    logic        [2:0]  hit_index;
    logic               moved;
    logic signed [10:0] delta_x;

    lane_mover dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .enable     (enable),
        .direction  (direction),
        .start_x    (start_x),
        .lane_y     (lane_y),
        .probe_x    (probe_x),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_width  (obj_width),
        .obj_height (obj_height),
        .probe_hit  (probe_hit),
        .hit_index  (hit_index),
        .moved      (moved),
        .delta_x    (delta_x)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string       name;
        logic [43:0] xs;
        logic        mv;
        logic [10:0] dx;
        logic [10:0] y;
        logic        hit;
        logic [2:0]  idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(string nm, int x0, int x1, int x2, int x3,
                                logic mv, int dx, int y, logic hit, int idx);
        exp_t e;
        e.name = nm;
        e.xs   = {11'(x3), 11'(x2), 11'(x1), 11'(x0)};
        e.mv   = mv;
        e.dx   = 11'(dx);
        e.y    = 11'(y);
        e.hit  = hit;
        e.idx  = 3'(idx);
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge frame_clk or posedge Reset);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (obj_x !== e.xs || moved !== e.mv || delta_x !== e.dx || obj_y !== e.y ||
                    probe_hit !== e.hit || hit_index !== e.idx ||
                    obj_width !== 11'd40 || obj_height !== 11'd40) begin
                    n_bad++;
                    $display("FAIL %s: got x=%0d,%0d,%0d,%0d y=%0d moved=%b dx=%0d hit=%b idx=%0d w=%0d h=%0d; want x=%0d,%0d,%0d,%0d y=%0d moved=%b dx=%0d hit=%b idx=%0d w=40 h=40",
                             e.name,
                             $signed(obj_x[10:0]), $signed(obj_x[21:11]), $signed(obj_x[32:22]), $signed(obj_x[43:33]),
                             obj_y, moved, delta_x, probe_hit, hit_index, obj_width, obj_height,
                             $signed(e.xs[10:0]), $signed(e.xs[21:11]), $signed(e.xs[32:22]), $signed(e.xs[43:33]),
                             e.y, e.mv, $signed(e.dx), e.hit, e.idx);
                end
            end
        end
    end

    task automatic cycle(input logic en, input logic dir, input int probe, input exp_t e);
        enable    = en;
        direction = dir;
        probe_x   = 11'(probe);
        @(posedge frame_clk);
        q.push_back(e);
        @(negedge frame_clk);
        #2;
    endtask

    // Called in the low clock phase; reset rises with no clock edge in between.
    task automatic do_reset(input int sx, input int y, input exp_t e);
        Reset = 1'b0;
        #1;
        start_x = 11'(sx);
        lane_y  = 11'(y);
        q.push_back(e);
        Reset = 1'b1;
        @(negedge frame_clk);
        #2;
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got time %0t, required finish before 20000", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        do_reset(0, 200, mk("reset0", 0, 170, 340, 510, 0, 0, 200, 0, 0));
        Reset = 1'b0;

        cycle(1, 0, -500, mk("a1",  0,   170, 340, 510, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a2",  0,   170, 340, 510, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a3",  -10, 160, 330, 500, 1, -10, 200, 0, 0));
        cycle(1, 0, -500, mk("a4",  -10, 160, 330, 500, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a5",  -10, 160, 330, 500, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a6",  -20, 150, 320, 490, 1, -10, 200, 0, 0));
        cycle(1, 0, -500, mk("a7",  -20, 150, 320, 490, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a8",  -20, 150, 320, 490, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a9",  -30, 140, 310, 480, 1, -10, 200, 0, 0));
        cycle(1, 0, -500, mk("a10", -30, 140, 310, 480, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a11", -30, 140, 310, 480, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("a12", 640, 130, 300, 470, 1, -10, 200, 0, 0));

        cycle(1, 0, -500, mk("b_cnt1", 640, 130, 300, 470, 0, 0, 200, 0, 0));
        for (int k = 0; k < 5; k++)
            cycle(0, 1, -500, mk("b_frozen", 640, 130, 300, 470, 0, 0, 200, 0, 0));
        cycle(1, 1, -500, mk("b_resume1", 640, 130, 300, 470, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("b_resume2", 630, 120, 290, 460, 1, -10, 200, 0, 0));
        cycle(0, 0, -500, mk("b_disable", 630, 120, 290, 460, 0,   0, 200, 0, 0));

        do_reset(100, 200, mk("c_reset", 100, 270, 440, 610, 0, 0, 200, 0, 0));
        cycle(1, 0, 100, mk("c_left_edge",  100, 270, 440, 610, 0, 0, 200, 1, 0));
        cycle(1, 0, 139, mk("c_right_in",   100, 270, 440, 610, 0, 0, 200, 1, 0));
        cycle(1, 0, 140, mk("c_right_out",  100, 270, 440, 610, 0, 0, 200, 0, 0));
        cycle(1, 0, 270, mk("c_obj1",       100, 270, 440, 610, 0, 0, 200, 1, 1));
        cycle(1, 0, 479, mk("c_obj2",       100, 270, 440, 610, 0, 0, 200, 1, 2));
        cycle(1, 0, 649, mk("c_obj3",       100, 270, 440, 610, 0, 0, 200, 1, 3));
        cycle(1, 0, 650, mk("c_obj3_out",   100, 270, 440, 610, 0, 0, 200, 0, 0));
        do_reset(-10, 200, mk("c_neg_reset", -10, 160, 330, 500, 0, 0, 200, 0, 0));
        cycle(1, 0, -5,  mk("c_neg_in",     -10, 160, 330, 500, 0, 0, 200, 1, 0));
        cycle(1, 0, 5,   mk("c_neg_span",   -10, 160, 330, 500, 0, 0, 200, 1, 0));
        cycle(1, 0, -11, mk("c_neg_below",  -10, 160, 330, 500, 0, 0, 200, 0, 0));
        cycle(1, 0, 30,  mk("c_neg_above",  -10, 160, 330, 500, 0, 0, 200, 0, 0));

        do_reset(630, 77, mk("d_reset", 630, 120, 290, 460, 0, 0, 77, 0, 0));
        Reset  = 1'b0;
        lane_y = 11'd300;
        cycle(1, 1, -500, mk("d1", 630, 120, 290, 460, 0,  0, 77, 0, 0));
        cycle(1, 1, -500, mk("d2", 630, 120, 290, 460, 0,  0, 77, 0, 0));
        cycle(1, 1, -35,  mk("d3", -40, 130, 300, 470, 1, 10, 77, 1, 0));
        cycle(1, 1, -500, mk("d4", -40, 130, 300, 470, 0,  0, 77, 0, 0));
        cycle(1, 1, -500, mk("d5", -40, 130, 300, 470, 0,  0, 77, 0, 0));
        cycle(1, 1, -500, mk("d6", -30, 140, 310, 480, 1, 10, 77, 0, 0));

        direction = 1'b0;
        do_reset(0, 200, mk("e_async_reset", 0, 170, 340, 510, 0, 0, 200, 0, 0));
        Reset = 1'b0;
        cycle(1, 0, -500, mk("e1", 0,   170, 340, 510, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("e2", 0,   170, 340, 510, 0,   0, 200, 0, 0));
        cycle(1, 0, -500, mk("e3", -10, 160, 330, 500, 1, -10, 200, 0, 0));

        @(negedge frame_clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_mover.md
Name: lane_mover

Overview:
Parametrised N-object lane for the Frogger playfield: lilypads, logs or cars. Holds NUM_OBJ evenly spaced objects that step horizontally on a frame-rate schedule and wrap around the screen edges. Reports per-object positions to the sprite/colour mapper. Also reports ride/collision information (probe hit, move delta) to the frog controller, so the frog can ride or die.

Parameters:
NUM_OBJ, 4, number of objects in the lane (1..8)
OBJ_W, 40, object width in pixels
OBJ_H, 40, object height in pixels
SCREEN_W, 640, visible screen width in pixels
STEP, 10, pixels moved per move event (1..OBJ_W)
WAIT_FRAMES, 2, idle frames between move events (0..255)
SPACING, 170, x distance between consecutive objects at reset

Ports:
frame_clk  in  1  frame-rate clock (vsync)
Reset  in  1  asynchronous, active-high
enable  in  1  1 = lane runs; 0 = freeze counter and positions
direction  in  1  0 = left, 1 = right; sampled at each move event
start_x  in  11  x of object 0 at reset, signed two's complement
lane_y  in  11  y of every object; registered at reset
probe_x  in  11  frog centre x, signed
obj_x  out  11*NUM_OBJ  packed signed x positions, object i at bits [11i+10:11i]
obj_y  out  11  lane y
obj_width  out  11  constant OBJ_W
obj_height  out  11  constant OBJ_H
probe_hit  out  1  probe_x lies inside some object
hit_index  out  3  lowest index of an object containing probe_x; 0 when no hit
moved  out  1  registered; high for the frame following a move event
delta_x  out  11  signed step applied at the last move event; 0 when moved=0

Behaviour:
- Coordinates are 11-bit signed two's complement; all compares are signed. Wrap period P = SCREEN_W + OBJ_W (680 at defaults).
- Reset, asynchronous:
  - obj_x[i] = (start_x + i*SPACING), reduced into [-OBJ_W, SCREEN_W) by subtracting P once if >= SCREEN_W.
  - obj_y = lane_y; frame counter cnt = 0; moved = 0; delta_x = 0.
- Schedule: single counter cnt in 0..WAIT_FRAMES, updated on each frame_clk edge with enable=1.
  - If cnt == WAIT_FRAMES: move event, cnt <= 0.
  - Otherwise cnt <= cnt + 1.
  - One move per WAIT_FRAMES+1 frames. With WAIT_FRAMES=2, the first move is on the 3rd edge after Reset deasserts.
- Move event, left (direction=0): n = x - STEP; if n <= -OBJ_W then x <= n + P, else x <= n.
- Move event, right (direction=1): n = x + STEP; if n >= SCREEN_W then x <= n - P, else x <= n.
- All objects update in the same edge; spacing is invariant.
- moved <= 1 and delta_x <= ±STEP on a move edge; moved <= 0 and delta_x <= 0 on every other edge.
- enable=0: cnt, positions, obj_y hold; moved <= 0, delta_x <= 0. Resuming continues from the held cnt.
- A direction change is sampled only at a move edge; no effect between moves.
- probe_hit/hit_index: combinational from registered obj_x. Hit when obj_x[i] <= probe_x < obj_x[i] + OBJ_W. Overlaps resolve to the lowest index.
- Reset mid-count or mid-move: all state returns to reset values immediately; no partial update survives.
- No MOVE/WAIT enumerated state is kept separately; cnt == WAIT_FRAMES is the MOVE condition.

Decomposition:
- Package frogger_pkg:
  - coord_t (logic signed [10:0])
  - SCREEN_W, SCREEN_H constants
  - dir_e enum {DIR_LEFT, DIR_RIGHT}
  - function wrap_step(coord_t x, dir_e d, step, w, screen) returning the new coordinate.
- Sub-module lane_object: one position register with reset value, move strobe, direction and wrap. lane_mover instantiates NUM_OBJ copies via generate, plus the shared counter, probe comparator tree and moved/delta registers.

Test Plan:
- Reset with start_x=0, defaults -> obj_x = 0, 170, 340, 510. moved=0, delta_x=0, obj_y=lane_y.
- direction=0, 12 frames -> moves on edges 3, 6, 9, 12. Object 0 goes -10 (11'h7F6), -20, -30, then wraps to 640 on the 4th move. moved pulses for exactly one frame after each move, with delta_x = -10 (11'h7F6).
- Reset start_x=630, NUM_OBJ=1, direction=1, 3 frames -> obj_x = -40 (11'h7D8); the next move gives -30.
- enable=0 for 5 frames starting at cnt=1 -> positions and cnt frozen, moved=0. Re-enable -> next move occurs exactly 2 edges later.
- Hit boundaries, obj_x[0]=100: probe_x=100 -> probe_hit=1, hit_index=0; probe_x=139 -> hit; probe_x=140 -> miss. probe_x=-5 with obj_x[0]=-10 -> hit (signed compare).
- Reset asserted asynchronously mid-frame after 2 moves -> outputs return to reset values before the next frame_clk edge; first subsequent move on the 3rd edge.
